// File: rtl/sincos_if.sv
// Request/result bundle for the sincos CORDIC rotator.
// The master drives the request fields; the slave returns the result and status.
interface sincos_if #(parameter int DATA_WIDTH = 32);
  logic                         start;
  logic signed [DATA_WIDTH-1:0] angle;
  logic signed [DATA_WIDTH-1:0] magnitude;
  logic signed [DATA_WIDTH-1:0] x;
  logic signed [DATA_WIDTH-1:0] y;
  logic                         busy;
  logic                         done;

  modport master (output start, angle, magnitude, input  x, y, busy, done);
  modport slave  (input  start, angle, magnitude, output x, y, busy, done);
endinterface

// File: rtl/sincos.sv
// Iterative CORDIC rotator: (x, y) = magnitude * (cos, sin)(angle), all values Q.10.
// Define SINCOS_GAIN_COMP_EN to pre-scale by 1/K so the outputs approximate unit gain.
module sincos #(
  parameter int DATA_WIDTH = 32,
  parameter int ITERATIONS = 12
) (
  input  logic     clock,
  input  logic     reset,
  sincos_if.slave  bus
);
  typedef logic signed [DATA_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, PREROT, ITER, DONE} state_t;

  localparam logic [3:0] LAST_I = 4'(ITERATIONS - 1);

  state_t     state_q, state_d;
  word_t      ang_q, ang_d, mag_q, mag_d;
  word_t      x_q, x_d, y_q, y_d, z_q, z_d;
  word_t      xo_q, xo_d, yo_q, yo_d;
  logic [3:0] i_q, i_d;
  logic       done_q, done_d;
  word_t      m;

  // atan(2^-i) scaled by 1024
  function automatic word_t atan_t(input logic [3:0] i);
    case (i)
      4'd0:    atan_t = word_t'(804);
      4'd1:    atan_t = word_t'(475);
      4'd2:    atan_t = word_t'(251);
      4'd3:    atan_t = word_t'(127);
      4'd4:    atan_t = word_t'(64);
      4'd5:    atan_t = word_t'(32);
      4'd6:    atan_t = word_t'(16);
      4'd7:    atan_t = word_t'(8);
      4'd8:    atan_t = word_t'(4);
      4'd9:    atan_t = word_t'(2);
      default: atan_t = word_t'(1);
    endcase
  endfunction

`ifdef SINCOS_GAIN_COMP_EN
  assign m = (mag_q * word_t'(622)) >>> 10;
`else
  assign m = mag_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PREROT;
      PREROT:  state_d = ITER;
      ITER:    if (i_q == LAST_I) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = done_q;
    bus.x    = xo_q;
    bus.y    = yo_q;
  end

  always_comb begin
    ang_d  = ang_q;
    mag_d  = mag_q;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    i_d    = i_q;
    xo_d   = xo_q;
    yo_d   = yo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        ang_d = bus.angle;
        mag_d = bus.magnitude;
      end
      PREROT: begin
        // Fold |angle| > pi/2 into range by a half-turn, absorbed as a sign flip on x
        y_d = '0;
        i_d = '0;
        if (ang_q > word_t'(1608)) begin
          z_d = ang_q - word_t'(3217);
          x_d = -m;
        end else if (ang_q < -word_t'(1608)) begin
          z_d = ang_q + word_t'(3217);
          x_d = -m;
        end else begin
          z_d = ang_q;
          x_d = m;
        end
      end
      ITER: begin
        i_d = i_q + 4'd1;
        if (!z_q[DATA_WIDTH-1]) begin
          x_d = x_q - (y_q >>> i_q);
          y_d = y_q + (x_q >>> i_q);
          z_d = z_q - atan_t(i_q);
        end else begin
          x_d = x_q + (y_q >>> i_q);
          y_d = y_q - (x_q >>> i_q);
          z_d = z_q + atan_t(i_q);
        end
      end
      DONE: begin
        xo_d   = x_q;
        yo_d   = y_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ang_q  <= '0;
      mag_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      i_q    <= '0;
      xo_q   <= '0;
      yo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      ang_q  <= ang_d;
      mag_q  <= mag_d;
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      i_q    <= i_d;
      xo_q   <= xo_d;
      yo_q   <= yo_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_sincos.sv
// Directed vector bench for sincos: table of angles with expected Q.10 results,
// plus hand-written sequences for ignored restarts and mid-run reset.
module tb_sincos;
  localparam int DW   = 32;
  localparam int ITER = 12;
  localparam int LAT  = ITER + 2;
`ifdef SINCOS_GAIN_COMP_EN
  localparam int MAG = 1024;
`else
  localparam int MAG = 622;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  sincos_if #(.DATA_WIDTH(DW)) bus();

  sincos #(.DATA_WIDTH(DW), .ITERATIONS(ITER)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int ang;
    int mag;
    int ex;
    int ey;
    int tol;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int got, input int exp, input int tol);
    n_chk++;
    if (got < exp - tol || got > exp + tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", nm, got, exp, tol);
    end
  endtask

  task automatic run_req(input int ang, input int mag, output int lat, output int rx, output int ry);
    @(negedge clock);
    bus.start = 1'b1; bus.angle = ang; bus.magnitude = mag;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    lat = 0; rx = 0; ry = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.done) begin
        lat = c; rx = bus.x; ry = bus.y;
        break;
      end
    end
  endtask

  vec_t vt[$];

  initial begin
    int lat, rx, ry, dones;
    bus.start = 1'b0; bus.angle = '0; bus.magnitude = '0;

    vt.push_back('{0,     MAG,  1025,  -1,   0});  // exact trace of the micro-rotations
    vt.push_back('{804,   MAG,  724,   724,  6});
    vt.push_back('{3217,  MAG, -1024,  0,    6});
    vt.push_back('{-1608, MAG,  0,    -1024, 6});
    vt.push_back('{1608,  MAG,  0,     1024, 6});
    vt.push_back('{1609,  MAG,  0,     1024, 6});
    vt.push_back('{-1609, MAG,  0,    -1024, 6});
    vt.push_back('{-804,  MAG,  724,  -724,  6});
    vt.push_back('{2413,  MAG, -724,   724,  6});
    vt.push_back('{-3217, MAG, -1024,  0,    6});
    vt.push_back('{536,   MAG,  887,   512,  6});
    vt.push_back('{0,    -MAG, -1024,  0,    6});
    vt.push_back('{1000,  0,    0,     0,    0});

    #1;
    chk("rst_x", bus.x, 0, 0);
    chk("rst_y", bus.y, 0, 0);
    chk("rst_busy", int'(bus.busy), 0, 0);
    chk("rst_done", int'(bus.done), 0, 0);
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < vt.size(); k++) begin
      run_req(vt[k].ang, vt[k].mag, lat, rx, ry);
      chk($sformatf("v%0d_lat", k), lat, LAT, 0);
      chk($sformatf("v%0d_x", k), rx, vt[k].ex, vt[k].tol);
      chk($sformatf("v%0d_y", k), ry, vt[k].ey, vt[k].tol);
      @(negedge clock);
      chk($sformatf("v%0d_pulse", k), int'(bus.done), 0, 0);
      chk($sformatf("v%0d_hold", k), bus.x, rx, 0);
      chk($sformatf("v%0d_idle", k), int'(bus.busy), 0, 0);
    end

    // Restart pulses while busy and in the DONE cycle must be ignored
    @(negedge clock);
    bus.start = 1'b1; bus.angle = 804; bus.magnitude = MAG;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    chk("rs_busy", int'(bus.busy), 1, 0);
    dones = 0; lat = 0; rx = 0; ry = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.done) begin
        dones++;
        if (lat == 0) begin lat = c; rx = bus.x; ry = bus.y; end
      end
      bus.start = (c == 2 || c == 13);
      bus.angle = -1608;
    end
    chk("rs_dones", dones, 1, 0);
    chk("rs_lat", lat, LAT, 0);
    chk("rs_x", rx, 724, 6);
    chk("rs_y", ry, 724, 6);
    chk("rs_idle", int'(bus.busy), 0, 0);

    // Reset mid-computation aborts the request without a done
    @(negedge clock);
    bus.start = 1'b1; bus.angle = 0; bus.magnitude = MAG;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    for (int c = 1; c <= 6; c++) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("ab_x", bus.x, 0, 0);
    chk("ab_y", bus.y, 0, 0);
    chk("ab_busy", int'(bus.busy), 0, 0);
    chk("ab_done", int'(bus.done), 0, 0);
    @(negedge clock);
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
    chk("ab_nodone", dones, 0, 0);
    chk("ab_idle", int'(bus.busy), 0, 0);

    run_req(-804, MAG, lat, rx, ry);
    chk("post_lat", lat, LAT, 0);
    chk("post_x", rx, 724, 6);
    chk("post_y", ry, -724, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sincos.md
SINCOS -- requirements
Module: sincos

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of all data ports, signed two's complement.
REQ-002 Parameter ITERATIONS, default 12, legal range 1..12: number of CORDIC micro-rotations.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request pulse, sampled only in IDLE.
REQ-006 angle  input  DATA_WIDTH  radians scaled by 1024 (Q.10), legal range -3217..+3217 (-pi..+pi).
REQ-007 magnitude  input  DATA_WIDTH  vector length in Q.10, legal |magnitude| < 2^20.
REQ-008 x  output  DATA_WIDTH  magnitude*cos(angle) in Q.10, registered.
REQ-009 y  output  DATA_WIDTH  magnitude*sin(angle) in Q.10, registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 The block SHALL implement FSM states IDLE, PREROT, ITER, DONE, encoded in 2 bits.
REQ-013 IDLE: start=1 at a rising edge SHALL capture angle and magnitude and move to PREROT; start=0 stays in IDLE.
REQ-014 PREROT, one cycle: angle > 1608 -> z0 = angle-3217, x0 = -m; angle < -1608 -> z0 = angle+3217, x0 = -m; otherwise z0 = angle, x0 = m; y0 = 0 in all cases; m defined in REQ-027/028.
REQ-015 ITER SHALL last exactly ITERATIONS cycles, iteration counter i = 0..ITERATIONS-1, then move to DONE.
REQ-016 Iteration i, z >= 0: x <= x - (y>>>i), y <= y + (x>>>i), z <= z - T[i]; z < 0: x <= x + (y>>>i), y <= y - (x>>>i), z <= z + T[i].
REQ-017 T[0..11] SHALL be the constants 804, 475, 251, 127, 64, 32, 16, 8, 4, 2, 1, 1.
REQ-018 All shifts SHALL be arithmetic; all arithmetic DATA_WIDTH-bit signed, wrapping, no saturation.
REQ-019 DONE, one cycle: done=1, x/y outputs loaded from the datapath, then return to IDLE.
REQ-020 done SHALL rise exactly ITERATIONS+2 cycles after the edge that accepted start (14 at default), with x/y valid in the same cycle.
REQ-021 x and y SHALL hold their last result until the next DONE.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the running computation or any queued request.
REQ-023 start asserted in the DONE cycle SHALL be ignored; a new request is accepted from IDLE only, so back-to-back throughput is one result per ITERATIONS+3 cycles.
REQ-024 angle outside -3217..3217 SHALL still complete with the normal timing, but x/y values are unspecified.
REQ-025 Accuracy, with gain compensation, |magnitude| <= 1024: |error| <= 6 LSB on each of x and y.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, x=0, y=0, busy=0, done=0 and clear the datapath registers and the counter, including mid-computation; the aborted request is discarded and no done is produced.

Configuration
REQ-027 With macro SINCOS_GAIN_COMP_EN defined, PREROT SHALL use m = (magnitude*622)>>>10 (1/K compensation, 622 = 0.60725*1024), so outputs approximate unit gain.
REQ-028 Without SINCOS_GAIN_COMP_EN, m = magnitude and outputs carry the CORDIC gain of about 1.6468; no multiplier is instantiated.

Verification
REQ-029 With comp on, angle=0, magnitude=1024 -> done at cycle 14, x=1024+/-6, y=0+/-6.
REQ-030 With comp on, magnitude=1024: angle=804 -> x,y = 724+/-6; angle=3217 -> x=-1024+/-6, y=0+/-6; angle=-1608 -> x=0+/-6, y=-1024+/-6.
REQ-031 Start accepted, then start re-pulsed at cycles 3 and 14 -> exactly one done, at cycle 14, result matches the first request.
REQ-032 reset=0 at cycle 6 of a computation -> outputs 0 and busy=0 immediately; no done; a fresh request afterwards completes normally.
REQ-033 Comp off, angle=0, magnitude=622 -> x=1024+/-6, y=0+/-6.
REQ-034 ITERATIONS=8 build: done SHALL arrive 10 cycles after the edge that accepted start.
